// File: rtl/prio_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc_pkg
//  Description : Shared constants and helpers for the pending priority encoder
//                and its selector.
//  Revision    : 1.0 - initial release
// ============================================================================
package prio_enc_pkg;

    // Arbitration modes
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Index width for n lines, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prio_sel.sv
`default_nettype none
// ============================================================================
//  Module      : prio_sel
//  Description : Combinational circular search. Starting at i_start and
//                moving downwards (wrapping from 0 to N-1), returns the first
//                set bit of i_vec.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_sel
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] i_vec,
    input  logic [W-1:0] i_start,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    int w_pos;

    // Walk the search order from its lowest-priority end so the last hit
    // written is the highest-priority one (position i_start itself).
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        for (int j = N - 1; j >= 0; j--) begin
            w_pos = int'(i_start) - j;
            if (w_pos < 0) begin
                w_pos = w_pos + N;
            end
            if (i_vec[w_pos[W-1:0]]) begin
                o_found = 1'b1;
                o_idx   = W'(w_pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pending_priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : pending_priority_encoder
//  Description : Collects event pulses into a pending register and presents
//                one pending, unmasked line at a time through a registered
//                valid/ready output. Fixed (highest index) or round-robin
//                ordering; flags requests that collapse into a pending line.
//  Revision    : 1.0 - initial release
// ============================================================================
module pending_priority_encoder
    import prio_enc_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = MODE_FIXED
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            req,
    input  logic [N-1:0]            mask,
    output logic [idx_width(N)-1:0] out_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N-1:0]            pending,
    output logic                    drop
);

    localparam int             W      = idx_width(N);
    localparam logic [W-1:0]   C_LAST = W'(N - 1);

    logic [N-1:0] r_pending;
    logic         r_valid;
    logic [W-1:0] r_idx;
    logic         r_drop;

    logic         w_accept;
    logic         w_load;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_pend_next;
    logic [N-1:0] w_cand;
    logic [N-1:0] w_drop_hit;
    logic [W-1:0] w_start;
    logic         w_found;
    logic [W-1:0] w_sel_idx;

    // Handshake, pending update (set wins over clear) and drop detection
    always_comb begin
        w_accept    = r_valid & out_ready;
        w_load      = ~r_valid | out_ready;
        w_clr       = w_accept ? (N'(1) << r_idx) : '0;
        w_pend_next = (r_pending & ~w_clr) | req;
        w_cand      = w_pend_next & ~mask;
        w_drop_hit  = req & r_pending & ~w_clr;
    end

    if (MODE == MODE_RR) begin : g_rr
        logic [W-1:0] r_ptr;
        logic [W-1:0] w_ptr_next;

        // Pointer moves to just below the accepted line; the selection in the
        // same cycle already uses the moved pointer.
        always_comb begin
            w_ptr_next = r_ptr;
            if (w_accept) begin
                w_ptr_next = (r_idx == '0) ? C_LAST : (r_idx - 1'b1);
            end
        end

        // Round-robin pointer register
        always_ff @(posedge clk) begin
            if (rst) begin
                r_ptr <= C_LAST;
            end else begin
                r_ptr <= w_ptr_next;
            end
        end

        assign w_start = w_ptr_next;
    end else begin : g_fixed
        assign w_start = C_LAST;
    end

    prio_sel #(
        .N (N),
        .W (W)
    ) u_sel (
        .i_vec   (w_cand),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_sel_idx)
    );

    // Pending, drop and output registers; output holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_pending <= w_pend_next;
            r_drop    <= |w_drop_hit;
            if (w_load) begin
                r_valid <= w_found;
                r_idx   <= w_found ? w_sel_idx : '0;
            end
        end
    end

    assign out_idx   = r_idx;
    assign out_valid = r_valid;
    assign pending   = r_pending;
    assign drop      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_pending_priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pending_priority_encoder
//  Description : Self-checking bench; drives a fixed-priority and a
//                round-robin instance (N=8) with the same stimulus and
//                compares both against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pending_priority_encoder;

    localparam int N = 8;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    mask;
    logic            rdy;

    logic [1:0]      d_valid;
    logic [1:0]      d_drop;
    logic [1:0][2:0] d_idx;
    logic [1:0][7:0] d_pend;

    // Model state, index 0 = fixed priority, 1 = round robin
    logic [7:0] m_pend [2];
    bit         m_valid[2];
    bit         m_drop [2];
    int         m_idx  [2];
    int         m_ptr  [2];

    int n_total;
    int n_pass;

    pending_priority_encoder #(.N(N), .MODE(0)) u_dut_fixed (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mask      (mask),
        .out_idx   (d_idx[0]),
        .out_valid (d_valid[0]),
        .out_ready (rdy),
        .pending   (d_pend[0]),
        .drop      (d_drop[0])
    );

    pending_priority_encoder #(.N(N), .MODE(1)) u_dut_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mask      (mask),
        .out_idx   (d_idx[1]),
        .out_valid (d_valid[1]),
        .out_ready (rdy),
        .pending   (d_pend[1]),
        .drop      (d_drop[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: predict from the current inputs, clock, then compare.
    task automatic step();
        logic [7:0] np  [2];
        bit         nv  [2];
        bit         nd  [2];
        int         ni  [2];
        int         nptr[2];
        bit         acc;
        int         start;
        int         line;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                np[m] = 8'h00; nv[m] = 1'b0; ni[m] = 0; nd[m] = 1'b0; nptr[m] = N - 1;
            end else begin
                acc   = m_valid[m] && rdy;
                nd[m] = 1'b0;
                for (int i = 0; i < N; i++) begin
                    bit cleared;
                    cleared  = acc && (i == m_idx[m]);
                    np[m][i] = (m_pend[m][i] && !cleared) || req[i];
                    if (req[i] && m_pend[m][i] && !cleared) nd[m] = 1'b1;
                end
                nptr[m] = acc ? ((m_idx[m] + N - 1) % N) : m_ptr[m];
                nv[m]   = m_valid[m];
                ni[m]   = m_idx[m];
                if (!m_valid[m] || rdy) begin
                    start = (m == 1) ? nptr[m] : N - 1;
                    nv[m] = 1'b0;
                    ni[m] = 0;
                    for (int k = 0; k < N; k++) begin
                        line = (start - k + N) % N;
                        if (!nv[m] && np[m][line] && !mask[line]) begin
                            nv[m] = 1'b1;
                            ni[m] = line;
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            m_pend[m]  = np[m];
            m_valid[m] = nv[m];
            m_idx[m]   = ni[m];
            m_drop[m]  = nd[m];
            m_ptr[m]   = nptr[m];
            check($sformatf("m%0d_valid", m), 64'(d_valid[m]), 64'(m_valid[m]));
            check($sformatf("m%0d_idx", m),   64'(d_idx[m]),   64'(m_idx[m]));
            check($sformatf("m%0d_pend", m),  64'(d_pend[m]),  64'(m_pend[m]));
            check($sformatf("m%0d_drop", m),  64'(d_drop[m]),  64'(m_drop[m]));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; mask = '0; rdy = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = 8'h00; m_valid[m] = 1'b0; m_drop[m] = 1'b0;
            m_idx[m] = 0; m_ptr[m] = N - 1;
        end
        rst = 1'b1; req = '0; mask = '0; rdy = 1'b0;
        step();
        check("rst_valid", 64'(d_valid), 64'd0);
        check("rst_pend",  64'(d_pend),  64'd0);

        // Fixed priority: two events drain highest index first
        rst = 1'b0; req = 8'h12; rdy = 1'b1;
        step(); check("fx_first_4", 64'(d_idx[0]), 64'd4);
        req = 8'h00;
        step(); check("fx_then_1", 64'(d_idx[0]), 64'd1);
        step(); check("fx_empty", 64'({d_valid[0], d_pend[0]}), 64'd0);

        // Stalled output holds despite a higher-priority arrival
        rdy = 1'b0; req = 8'h04;
        step();
        req = 8'h80;
        step(); check("fx_hold_2", 64'(d_idx[0]), 64'd2);
        req = 8'h00;
        step(); check("fx_still_2", 64'(d_idx[0]), 64'd2);
        rdy = 1'b1;
        step(); check("fx_next_7", 64'(d_idx[0]), 64'd7);
        step();

        // Round robin: full pending drains 7 down to 0
        do_reset();
        req = 8'hFF;
        step(); check("rr_first_7", 64'(d_idx[1]), 64'd7);
        req = 8'h00; rdy = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step(); check($sformatf("rr_order_%0d", k), 64'(d_idx[1]), 64'(6 - k));
        end
        step(); check("rr_drained", 64'(d_valid[1]), 64'd0);

        // Round robin: re-request of the accepted line waits its turn
        do_reset();
        req = 8'h88;
        step(); check("rr_pick_7", 64'(d_idx[1]), 64'd7);
        req = 8'h80; rdy = 1'b1;
        step(); check("rr_then_3", 64'(d_idx[1]), 64'd3);
        req = 8'h00;
        step(); check("rr_back_7", 64'(d_idx[1]), 64'd7);

        // Duplicate request on a pending line
        do_reset();
        req = 8'h20;
        step(); check("dup_nodrop", 64'(d_drop), 64'd0);
        step(); check("dup_drop", 64'(d_drop), 64'd3);
        req = 8'h00;
        step(); check("dup_pulse", 64'(d_drop), 64'd0);
        rdy = 1'b1;
        step(); check("dup_accepted", 64'({d_valid, d_pend[0], d_pend[1]}), 64'd0);

        // Full mask retains pending; unmask re-presents
        do_reset();
        mask = 8'hFF; req = 8'h81;
        step(); check("msk_invalid", 64'(d_valid), 64'd0);
        check("msk_retain", 64'(d_pend[0]), 64'h81);
        mask = 8'h00; req = 8'h00;
        step(); check("msk_idx7", 64'({d_valid[0], d_idx[0]}), 64'h0F);

        // Reset while stalled
        rdy = 1'b0; rst = 1'b1;
        step(); check("rst_stall", 64'({d_valid, d_idx[0], d_idx[1], d_pend[0], d_pend[1]}), 64'd0);
        rst = 1'b0;

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            rst  = ($urandom_range(0, 60) == 0);
            req  = 8'($urandom & $urandom & $urandom);
            mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            rdy  = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
